// File: rtl/prog_mem_loader.sv
// Writable instruction memory with a valid/ready program loader; stalls the CPU via HOLD while clearing or loading.
// Optional checksum beat on LD_LAST is enabled with `define PROG_MEM_CHECKSUM_EN.
module prog_mem_loader #(
  parameter int unsigned DATA_W = 10,
  parameter int unsigned ADDR_W = 6,
  parameter int unsigned DEPTH  = 1 << ADDR_W
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic [ADDR_W-1:0] AD,
  output logic [DATA_W-1:0] Q,
  output logic              HOLD,
  input  logic              LD_START,
  input  logic              LD_VALID,
  output logic              LD_READY,
  input  logic [DATA_W-1:0] LD_DATA,
  input  logic              LD_LAST,
  output logic [ADDR_W:0]   LD_COUNT,
  output logic              OVF,
  output logic              ERR
);

  typedef enum logic [1:0] {S_CLEAR, S_RUN, S_LOAD} state_t;

  localparam logic [ADDR_W:0]   DEPTH_L = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_A  = ADDR_W'(DEPTH - 1);

  state_t            state;
  logic [ADDR_W-1:0] clr_ptr;
  logic [DATA_W-1:0] mem [DEPTH];

  logic              take;
  logic              room;
  logic              store;
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;

  assign HOLD     = (state != S_RUN);
  assign LD_READY = (state == S_LOAD);

  always_comb begin
    take  = (state == S_LOAD) && LD_VALID;
    room  = (LD_COUNT < DEPTH_L);
`ifdef PROG_MEM_CHECKSUM_EN
    // The LD_LAST beat carries the checksum and is never written to memory.
    store = take && room && !LD_LAST;
`else
    store = take && room;
`endif
    we    = (state == S_CLEAR) || store;
    waddr = (state == S_CLEAR) ? clr_ptr : LD_COUNT[ADDR_W-1:0];
    wdata = (state == S_CLEAR) ? '0 : LD_DATA;
  end

  always_ff @(posedge CLK) begin
    if (we) mem[waddr] <= wdata;
  end

  always_comb begin
    Q = '0;
    if (state == S_RUN && {1'b0, AD} < DEPTH_L) Q = mem[AD];
  end

`ifdef PROG_MEM_CHECKSUM_EN
  logic [DATA_W-1:0] sum;
`else
  assign ERR = 1'b0;
`endif

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state    <= S_CLEAR;
      clr_ptr  <= '0;
      LD_COUNT <= '0;
      OVF      <= 1'b0;
`ifdef PROG_MEM_CHECKSUM_EN
      ERR      <= 1'b0;
      sum      <= '0;
`endif
    end else begin
      case (state)
        S_CLEAR: begin
          clr_ptr <= clr_ptr + 1'b1;
          if (clr_ptr == LAST_A) state <= S_RUN;
        end
        S_RUN: begin
          if (LD_START) begin
            state    <= S_LOAD;
            LD_COUNT <= '0;
            OVF      <= 1'b0;
`ifdef PROG_MEM_CHECKSUM_EN
            ERR      <= 1'b0;
            sum      <= '0;
`endif
          end
        end
        S_LOAD: begin
          if (take) begin
            if (store) begin
              LD_COUNT <= LD_COUNT + 1'b1;
`ifdef PROG_MEM_CHECKSUM_EN
              sum      <= sum + LD_DATA;
`endif
            end
`ifdef PROG_MEM_CHECKSUM_EN
            if (!room && !LD_LAST) OVF <= 1'b1;
            if (LD_LAST) ERR <= (LD_DATA != sum);
`else
            if (!room) OVF <= 1'b1;
`endif
            if (LD_LAST) state <= S_RUN;
          end
        end
        default: state <= S_CLEAR;
      endcase
    end
  end

endmodule

// File: tb/tb_prog_mem_loader.sv
// Scoreboard bench for prog_mem_loader: stimulus pushes expectations, a negedge monitor pops and compares.
// Reference model is a plain array plus counters; honours PROG_MEM_CHECKSUM_EN when defined.
module tb_prog_mem_loader;

  localparam int unsigned DW = 10;
  localparam int unsigned AW = 6;
  localparam int unsigned D  = 64;

  logic          CLK = 1'b0;
  logic          RST_N;
  logic [AW-1:0] AD;
  logic [DW-1:0] Q;
  logic          HOLD;
  logic          LD_START;
  logic          LD_VALID;
  logic          LD_READY;
  logic [DW-1:0] LD_DATA;
  logic          LD_LAST;
  logic [AW:0]   LD_COUNT;
  logic          OVF;
  logic          ERR;

  prog_mem_loader #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(D)) dut (
    .CLK(CLK), .RST_N(RST_N), .AD(AD), .Q(Q), .HOLD(HOLD),
    .LD_START(LD_START), .LD_VALID(LD_VALID), .LD_READY(LD_READY),
    .LD_DATA(LD_DATA), .LD_LAST(LD_LAST), .LD_COUNT(LD_COUNT),
    .OVF(OVF), .ERR(ERR)
  );

  always #5 CLK = ~CLK;

  typedef enum {K_Q, K_HOLD, K_READY, K_COUNT, K_OVF, K_ERR} kind_t;
  typedef struct {
    kind_t       kind;
    int unsigned val;
    string       name;
  } exp_t;

  exp_t        exp_q[$];
  logic        probe = 1'b0;
  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  int unsigned mdl [D];
  int unsigned mcount;
  bit          movf;
  bit          merr;

  always @(negedge CLK) begin : monitor
    exp_t        e;
    int unsigned act;
    if (probe) begin
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        case (e.kind)
          K_Q:     act = int'(Q);
          K_HOLD:  act = int'(HOLD);
          K_READY: act = int'(LD_READY);
          K_COUNT: act = int'(LD_COUNT);
          K_OVF:   act = int'(OVF);
          default: act = int'(ERR);
        endcase
        n_cmp++;
        if (act != e.val) begin
          n_bad++;
          $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", e.name, act, e.val, $time);
        end
      end
    end
  end

  task automatic chk(input kind_t k, input int unsigned v, input string nm);
    exp_t e;
    e.kind = k;
    e.val  = v;
    e.name = nm;
    exp_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic step();
    probe = 1'b1;
    tick();
    probe = 1'b0;
  endtask

  task automatic read_all();
    for (int a = 0; a < int'(D); a++) begin
      AD       = AW'(a);
      LD_VALID = 1'($urandom_range(0, 1));
      LD_DATA  = DW'($urandom);
      LD_LAST  = 1'($urandom_range(0, 1));
      chk(K_Q, mdl[a], $sformatf("q[%0d]", a));
      step();
    end
    LD_VALID = 1'b0;
    LD_LAST  = 1'b0;
  endtask

  task automatic clear_sequence();
    for (int i = 0; i < int'(D); i++) begin
      chk(K_HOLD, 1, $sformatf("hold_clear_c%0d", i));
      if (i == 0) chk(K_COUNT, 0, "count_after_reset");
      step();
    end
    chk(K_HOLD, 0, "hold_after_clear");
    chk(K_READY, 0, "ready_after_clear");
    step();
  endtask

  task automatic do_reset();
    RST_N = 1'b0;
    for (int i = 0; i < int'(D); i++) mdl[i] = 0;
    mcount = 0;
    movf   = 1'b0;
    merr   = 1'b0;
    chk(K_HOLD, 1, "reset_hold");
    chk(K_READY, 0, "reset_ready");
    chk(K_COUNT, 0, "reset_count");
    chk(K_OVF, 0, "reset_ovf");
    chk(K_ERR, 0, "reset_err");
    chk(K_Q, 0, "reset_q");
    step();
    RST_N = 1'b1;
    clear_sequence();
  endtask

  // mode: 0 = back-to-back beats, 1 = idle cycle between beats, 2 = random gaps
  task automatic do_load(input int unsigned w[$], input int mode, input bit start_valid);
    int unsigned sum;
    int          g;
    bit          last;
    LD_START = 1'b1;
    LD_VALID = start_valid;
    LD_DATA  = DW'($urandom);
    LD_LAST  = 1'b0;
    tick();
    LD_START = 1'b0;
    LD_VALID = 1'b0;
    mcount = 0;
    movf   = 1'b0;
    merr   = 1'b0;
    sum    = 0;
    chk(K_READY, 1, "ready_in_load");
    chk(K_HOLD, 1, "hold_in_load");
    chk(K_Q, 0, "q_zero_in_load");
    chk(K_COUNT, 0, "count_at_start");
    chk(K_OVF, 0, "ovf_at_start");
    step();
    foreach (w[i]) begin
      last = (i == w.size() - 1);
      g = (mode == 1) ? int'(i > 0) : (mode == 2) ? int'($urandom_range(0, 2)) : 0;
      repeat (g) begin
        LD_DATA = DW'($urandom);
        LD_LAST = 1'($urandom_range(0, 1));
        tick();
      end
      LD_VALID = 1'b1;
      LD_DATA  = DW'(w[i]);
      LD_LAST  = last;
      tick();
      LD_VALID = 1'b0;
      LD_LAST  = 1'b0;
`ifdef PROG_MEM_CHECKSUM_EN
      if (last) begin
        merr = (w[i] != sum);
        continue;
      end
`endif
      if (mcount < D) begin
        mdl[mcount] = w[i];
        mcount++;
        sum = (sum + w[i]) % (1 << DW);
      end else begin
        movf = 1'b1;
      end
    end
    chk(K_HOLD, 0, "hold_after_last");
    chk(K_READY, 0, "ready_after_last");
    chk(K_COUNT, mcount, "ld_count");
    chk(K_OVF, int'(movf), "ovf");
    chk(K_ERR, int'(merr), "err");
    step();
    read_all();
  endtask

  initial begin : stim
    int unsigned w[$];
    int unsigned len;
    int unsigned s;
    RST_N    = 1'b0;
    AD       = '0;
    LD_START = 1'b0;
    LD_VALID = 1'b0;
    LD_DATA  = '0;
    LD_LAST  = 1'b0;
    tick();
    do_reset();
    read_all();

    w = '{32'h13E, 32'h000, 32'h041, 32'h302};
    do_load(w, 0, 1'b0);
    AD = '0;
    w = '{32'h2AA, 32'h155, 32'h0F0, 32'h3FF};
    do_load(w, 1, 1'b1);

    w = {};
    for (int i = 0; i < 66; i++) w.push_back($urandom_range(0, (1 << DW) - 1));
    do_load(w, 0, 1'b0);

`ifdef PROG_MEM_CHECKSUM_EN
    w = '{32'h105, 32'h20A, 32'h30F};
    do_load(w, 0, 1'b0);
    w = '{32'h105, 32'h20A, 32'h300};
    do_load(w, 2, 1'b0);
`endif

    for (int n = 0; n < 6; n++) begin
      len = $urandom_range(1, 70);
      w = {};
      for (int i = 0; i < int'(len); i++) w.push_back($urandom_range(0, (1 << DW) - 1));
`ifdef PROG_MEM_CHECKSUM_EN
      if ($urandom_range(0, 1) == 1) begin
        s = 0;
        for (int i = 0; i < int'(len) - 1 && i < int'(D); i++) s = (s + w[i]) % (1 << DW);
        w[len-1] = s;
      end
`else
      s = 0;
`endif
      do_load(w, int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
    end

    LD_START = 1'b1;
    tick();
    LD_START = 1'b0;
    for (int i = 0; i < 2; i++) begin
      LD_VALID = 1'b1;
      LD_DATA  = DW'($urandom_range(1, (1 << DW) - 1));
      tick();
    end
    LD_VALID = 1'b0;
    do_reset();
    read_all();

    tick();
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "timeout");
  end

endmodule
